// File: rtl/controlpack.sv
// Shared types for the register access controller and register file.
// Register-file commands, selects, instruction kinds and FSM states.
package controlpack;

  typedef enum logic {
    REG_NOP,
    REG_WRITE
  } registers_op_e;

  typedef enum logic [1:0] {
    REG_SEL_0,
    REG_SEL_1,
    REG_SEL_2,
    REG_SEL_3
  } register_sel_e;

  typedef enum logic [1:0] {
    INSTR_ALU,
    INSTR_LOADI,
    INSTR_MOV,
    INSTR_STORE
  } reg_instr_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB
  } reg_ctrl_state_e;

  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/reg_access_ctrl.sv
// Sequences register reads, execution-unit handoff and write-back.
// One FSM plus latched instruction fields and operands.
module reg_access_ctrl
  import controlpack::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int EXEC_TIMEOUT   = 15
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  reg_instr_kind_e           instr_kind,
  input  register_sel_e             instr_dst,
  input  register_sel_e             instr_src1,
  input  register_sel_e             instr_src2,
  input  logic [DATA_BUS_WIDTH-1:0] instr_imm,
  output registers_op_e             reg_op,
  output register_sel_e             reg_in_sel,
  output register_sel_e             reg_1_out_sel,
  output register_sel_e             reg_2_out_sel,
  output logic [DATA_BUS_WIDTH-1:0] reg_data_in,
  input  logic [DATA_BUS_WIDTH-1:0] reg_1_out,
  input  logic [DATA_BUS_WIDTH-1:0] reg_2_out,
  output logic                      exec_req,
  output logic [DATA_BUS_WIDTH-1:0] exec_a,
  output logic [DATA_BUS_WIDTH-1:0] exec_b,
  input  logic                      exec_done,
  input  logic [DATA_BUS_WIDTH-1:0] exec_result,
  output logic                      busy,
  output logic                      err
);

  localparam int CW = cnt_width(EXEC_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(EXEC_TIMEOUT - 1);

  reg_ctrl_state_e           state;
  reg_instr_kind_e           kind;
  register_sel_e             dst;
  register_sel_e             src1;
  register_sel_e             src2;
  logic [DATA_BUS_WIDTH-1:0] opa;
  logic [DATA_BUS_WIDTH-1:0] opb;
  logic [DATA_BUS_WIDTH-1:0] result;
  logic [CW-1:0]             cnt;

  // Controller FSM with instruction, operand and result latches
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      kind   <= INSTR_ALU;
      dst    <= REG_SEL_0;
      src1   <= REG_SEL_0;
      src2   <= REG_SEL_0;
      opa    <= '0;
      opb    <= '0;
      result <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            kind <= instr_kind;
            dst  <= instr_dst;
            src1 <= instr_src1;
            src2 <= instr_src2;
            err  <= 1'b0;
            if (instr_kind == INSTR_LOADI) begin
              result <= instr_imm;
              state  <= ST_WB;
            end else begin
              state  <= ST_READ;
            end
          end
        end
        ST_READ: begin
          opa <= reg_1_out;
          opb <= reg_2_out;
          cnt <= '0;
          if (kind == INSTR_MOV) begin
            result <= reg_1_out;
            state  <= ST_WB;
          end else begin
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_done) begin
            if (kind == INSTR_ALU) begin
              result <= exec_result;
              state  <= ST_WB;
            end else begin
              state  <= ST_IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign instr_ready   = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign exec_req      = (state == ST_EXEC);
  assign exec_a        = opa;
  assign exec_b        = opb;
  assign reg_1_out_sel = src1;
  assign reg_2_out_sel = src2;
  assign reg_in_sel    = dst;
  assign reg_op        = (state == ST_WB) ? REG_WRITE : REG_NOP;
  assign reg_data_in   = (state == ST_WB) ? result : '0;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl.
// Write-backs are checked against a queue of expected writes.
module tb_reg_access_ctrl;
  import controlpack::*;

  localparam int W = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  reg_instr_kind_e instr_kind = INSTR_ALU;
  register_sel_e   instr_dst = REG_SEL_0;
  register_sel_e   instr_src1 = REG_SEL_0;
  register_sel_e   instr_src2 = REG_SEL_0;
  logic [W-1:0]    instr_imm = '0;
  registers_op_e   reg_op;
  register_sel_e   reg_in_sel;
  register_sel_e   reg_1_out_sel;
  register_sel_e   reg_2_out_sel;
  logic [W-1:0]    reg_data_in;
  logic [W-1:0]    reg_1_out;
  logic [W-1:0]    reg_2_out;
  logic            exec_req;
  logic [W-1:0]    exec_a;
  logic [W-1:0]    exec_b;
  logic            exec_done = 1'b0;
  logic [W-1:0]    exec_result = '0;
  logic            busy;
  logic            err;

  logic [W-1:0] rf [4];
  logic [9:0]   sb [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  assign reg_1_out = rf[reg_1_out_sel];
  assign reg_2_out = rf[reg_2_out_sel];

  reg_access_ctrl #(
    .DATA_BUS_WIDTH(W),
    .EXEC_TIMEOUT(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_kind(instr_kind),
    .instr_dst(instr_dst),
    .instr_src1(instr_src1),
    .instr_src2(instr_src2),
    .instr_imm(instr_imm),
    .reg_op(reg_op),
    .reg_in_sel(reg_in_sel),
    .reg_1_out_sel(reg_1_out_sel),
    .reg_2_out_sel(reg_2_out_sel),
    .reg_data_in(reg_data_in),
    .reg_1_out(reg_1_out),
    .reg_2_out(reg_2_out),
    .exec_req(exec_req),
    .exec_a(exec_a),
    .exec_b(exec_b),
    .exec_done(exec_done),
    .exec_result(exec_result),
    .busy(busy),
    .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input reg_instr_kind_e k, input int d,
                       input int s1, input int s2,
                       input logic [W-1:0] imm, input bit wr,
                       input logic [W-1:0] wd);
    logic [1:0] ds;
    int t;
    t = 0;
    while (!instr_ready && t < 50) begin
      tick();
      t++;
    end
    chk("ready_wait", instr_ready, 1);
    ds = 2'(d);
    instr_kind  = k;
    instr_dst   = register_sel_e'(ds);
    instr_src1  = register_sel_e'(2'(s1));
    instr_src2  = register_sel_e'(2'(s2));
    instr_imm   = imm;
    instr_valid = 1'b1;
    if (wr) sb.push_back({ds, wd});
    tick();
    instr_valid = 1'b0;
  endtask

  // Scoreboard: every register write must match the oldest expectation
  always @(negedge clock) begin
    if (reg_op === REG_WRITE) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $error("FAIL wb_unexpected observed=%0h expected=none",
               {reg_in_sel, reg_data_in});
      end else begin
        chk("wb", {reg_in_sel, reg_data_in}, sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rf[0] = 8'h10;
    rf[1] = 8'h22;
    rf[2] = 8'h00;
    rf[3] = 8'h00;

    // Reset, with an instruction offered that must be ignored
    reset       = 1'b1;
    instr_kind  = INSTR_LOADI;
    instr_dst   = REG_SEL_2;
    instr_imm   = 8'h77;
    instr_valid = 1'b1;
    repeat (2) tick();
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_exec_req", exec_req, 0);
    chk("rst_reg_op", reg_op, REG_NOP);
    chk("rst_data_in", reg_data_in, 0);
    chk("rst_exec_a", exec_a, 0);
    chk("rst_exec_b", exec_b, 0);
    chk("rst_sels", {reg_in_sel, reg_1_out_sel, reg_2_out_sel}, 0);
    chk("rst_err", err, 0);
    instr_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    // LOADI: write in first cycle after accept
    issue(INSTR_LOADI, 2, 0, 0, 8'hA5, 1'b1, 8'hA5);
    chk("loadi_op", reg_op, REG_WRITE);
    chk("loadi_sel", reg_in_sel, 2);
    chk("loadi_data", reg_data_in, 8'hA5);
    chk("loadi_ready", instr_ready, 0);
    tick();
    chk("loadi_idle", busy, 0);
    chk("loadi_data0", reg_data_in, 0);

    // MOV: write in second cycle, instr_valid ignored while busy
    rf[1] = 8'h3C;
    issue(INSTR_MOV, 3, 1, 0, 8'h00, 1'b1, 8'h3C);
    chk("mov_rsel", reg_1_out_sel, 1);
    chk("mov_read_nop", reg_op, REG_NOP);
    instr_kind  = INSTR_LOADI;
    instr_dst   = REG_SEL_0;
    instr_imm   = 8'hFF;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    chk("mov_op", reg_op, REG_WRITE);
    chk("mov_data", reg_data_in, 8'h3C);
    tick();
    chk("mov_idle", busy, 0);

    // ALU: exec_done in second EXEC cycle
    rf[0] = 8'h10;
    rf[1] = 8'h22;
    issue(INSTR_ALU, 2, 0, 1, 8'h00, 1'b1, 8'h32);
    tick();
    chk("alu_req", exec_req, 1);
    chk("alu_a", exec_a, 8'h10);
    chk("alu_b", exec_b, 8'h22);
    chk("alu_exec_nop", reg_op, REG_NOP);
    tick();
    exec_done   = 1'b1;
    exec_result = 8'h32;
    tick();
    exec_done = 1'b0;
    chk("alu_op", reg_op, REG_WRITE);
    chk("alu_data", reg_data_in, 8'h32);
    tick();
    chk("alu_idle", busy, 0);

    // ALU: exec_done in first EXEC cycle, write in third cycle
    issue(INSTR_ALU, 1, 1, 0, 8'h00, 1'b1, 8'h55);
    tick();
    exec_done   = 1'b1;
    exec_result = 8'h55;
    tick();
    exec_done = 1'b0;
    chk("alu3_op", reg_op, REG_WRITE);
    chk("alu3_sel", reg_in_sel, 1);
    tick();

    // exec_done outside EXEC has no effect
    exec_done   = 1'b1;
    exec_result = 8'hEE;
    repeat (3) tick();
    chk("stray_done_busy", busy, 0);
    chk("stray_done_op", reg_op, REG_NOP);
    exec_done = 1'b0;

    // STORE timeout: 15 EXEC cycles then err
    issue(INSTR_STORE, 0, 2, 3, 8'h00, 1'b0, 8'h00);
    repeat (15) tick();
    chk("to_last_busy", busy, 1);
    chk("to_last_err", err, 0);
    chk("to_last_req", exec_req, 1);
    tick();
    chk("to_err", err, 1);
    chk("to_busy", busy, 0);
    chk("to_ready", instr_ready, 1);

    // STORE: accept clears err, done in 15th EXEC cycle wins
    issue(INSTR_STORE, 0, 0, 0, 8'h00, 1'b0, 8'h00);
    chk("err_cleared", err, 0);
    repeat (15) tick();
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("edge_err", err, 0);
    chk("edge_busy", busy, 0);

    // Reset during EXEC aborts the ALU instruction
    issue(INSTR_ALU, 3, 1, 1, 8'h00, 1'b0, 8'h00);
    tick();
    chk("abort_req", exec_req, 1);
    reset = 1'b1;
    tick();
    reset       = 1'b0;
    exec_done   = 1'b1;
    exec_result = 8'h99;
    tick();
    exec_done = 1'b0;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_ready", instr_ready, 1);
    chk("abort_op", reg_op, REG_NOP);
    chk("abort_req0", exec_req, 0);
    chk("abort_ab", {exec_a, exec_b}, 0);
    chk("abort_sels", {reg_in_sel, reg_1_out_sel, reg_2_out_sel}, 0);
    chk("abort_data", reg_data_in, 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
